// File: rtl/velocity_ramp.sv
// Slew-rate-limited velocity generator with a tick prescaler and a host watchdog.
// The watchdog brings velocity back to zero at the accel rate if the host stops writing.
module velocity_ramp #(
  parameter int F = 10,
  parameter int A = 6,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [F:0]   wdata,
  input  logic [A-1:0] accel,
  input  logic [D-1:0] div,
  input  logic [7:0]   wdtime,
  output logic [F:0]   velocity,
  output logic         enable,
  output logic         at_target,
  output logic         wd_trip
);

  typedef enum logic [1:0] {HOLD, SLEW, STOP, HALTED} state_t;

  localparam logic [D-1:0] ONE_D  = 1;
  localparam logic [F:0]   MOST_NEG = {1'b1, {F{1'b0}}};
  localparam logic [F:0]   CLAMPED  = {1'b1, {(F-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [D-1:0] cnt_q, cnt_d;
  logic [7:0]   wd_cnt_q, wd_cnt_d;
  logic [F:0]   target_q, target_d;
  logic [F:0]   velocity_q, velocity_d;
  logic         wd_trip_q, wd_trip_d;
  logic         enable_q, enable_d;
  logic         at_target_q, at_target_d;

  logic         tick;
  logic [F:0]   eff_target, eff_target_next;
  logic [F+1:0] diff, mag, accel_x;

  always_comb begin
    tick  = (cnt_q == '0);
    cnt_d = tick ? div : cnt_q - ONE_D;

    // The slew step uses the state as it stood before any coincident write.
    eff_target = wd_trip_q ? '0 : target_q;
    diff       = {eff_target[F], eff_target} - {velocity_q[F], velocity_q};
    mag        = diff[F+1] ? -diff : diff;
    accel_x    = {{(F+2-A){1'b0}}, accel};

    velocity_d = velocity_q;
    if (tick) begin
      if (accel == '0 || mag <= accel_x)
        velocity_d = eff_target;
      else if (!diff[F+1])
        velocity_d = velocity_q + accel_x[F:0];
      else
        velocity_d = velocity_q - accel_x[F:0];
    end

    target_d  = target_q;
    wd_trip_d = wd_trip_q;
    wd_cnt_d  = wd_cnt_q;
    if (wr) begin
      target_d  = (wdata == MOST_NEG) ? CLAMPED : wdata;
      wd_trip_d = 1'b0;
      wd_cnt_d  = wdtime;
    end else if (tick && !wd_trip_q && wdtime != 8'd0) begin
      if (wd_cnt_q == 8'd0)
        wd_trip_d = 1'b1;
      else
        wd_cnt_d = wd_cnt_q - 8'd1;
    end

    eff_target_next = wd_trip_d ? '0 : target_d;

    if (wd_trip_d)
      state_d = (velocity_d == '0) ? HALTED : STOP;
    else
      state_d = (velocity_d == eff_target_next) ? HOLD : SLEW;

    at_target_d = (velocity_d == eff_target_next);
    // Lags the state by one clk so the step generator sees its last zero-velocity cycle.
    enable_d    = (state_q != HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HOLD;
      cnt_q       <= div;
      wd_cnt_q    <= wdtime;
      target_q    <= '0;
      velocity_q  <= '0;
      wd_trip_q   <= 1'b0;
      enable_q    <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      target_q    <= target_d;
      velocity_q  <= velocity_d;
      wd_trip_q   <= wd_trip_d;
      enable_q    <= enable_d;
      at_target_q <= at_target_d;
    end
  end

  assign velocity  = velocity_q;
  assign enable    = enable_q;
  assign at_target = at_target_q;
  assign wd_trip   = wd_trip_q;

endmodule

// File: tb/tb_velocity_ramp.sv
// Directed checks of velocity_ramp: reset, ramps, odd remainders, tick alignment,
// watchdog stop, clamp and mid-ramp reset, with hand-computed expectations.
module tb_velocity_ramp;

  localparam int F = 10;
  localparam int A = 6;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr;
  logic [F:0]   wdata;
  logic [A-1:0] accel;
  logic [D-1:0] div;
  logic [7:0]   wdtime;
  logic [F:0]   velocity;
  logic         enable;
  logic         at_target;
  logic         wd_trip;

  int n_checks = 0;
  int n_errors = 0;

  velocity_ramp #(.F(F), .A(A), .D(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .wdata     (wdata),
    .accel     (accel),
    .div       (div),
    .wdtime    (wdtime),
    .velocity  (velocity),
    .enable    (enable),
    .at_target (at_target),
    .wd_trip   (wd_trip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int vel();
    return $signed(velocity);
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int ramp_exp[5];
    int odd_exp[4];
    ramp_exp = '{4, 8, 12, 16, 20};
    odd_exp  = '{12, 4, -4, -5};

    // Reset state; a write during reset must be ignored.
    reset = 1'b1; wr = 1'b1; wdata = 11'd20; accel = 6'd4; div = 8'd0; wdtime = 8'd0;
    step(3);
    check("rst_velocity", vel(), 0);
    check("rst_enable", int'(enable), 0);
    check("rst_at_target", int'(at_target), 1);
    check("rst_wd_trip", int'(wd_trip), 0);
    reset = 1'b0; wr = 1'b0;
    step(1);
    check("post_rst_enable", int'(enable), 1);
    check("post_rst_at_target", int'(at_target), 1);

    // Basic ramp to 20 at accel 4, one step per clk.
    wr = 1'b1; wdata = 11'd20;
    step(1);
    wr = 1'b0;
    check("ramp_wr_cycle", vel(), 0);
    check("ramp_wr_at_target", int'(at_target), 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("ramp_step%0d", i), vel(), ramp_exp[i]);
    end
    check("ramp_at_target", int'(at_target), 1);
    check("ramp_no_wd", int'(wd_trip), 0);

    // Odd remainder from 20 to -5 at accel 8, sign bit flips on the step to -4.
    accel = 6'd8; wr = 1'b1; wdata = 11'h7FB;
    step(1);
    wr = 1'b0;
    check("odd_wr_cycle", vel(), 20);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check($sformatf("odd_step%0d", i), vel(), odd_exp[i]);
      if (i == 1) check("odd_sign_pos", int'(velocity[F]), 0);
      if (i == 2) check("odd_sign_neg", int'(velocity[F]), 1);
    end
    check("odd_at_target", int'(at_target), 1);

    // Reset mid-ramp, then first tick div+1 clks after release.
    reset = 1'b1;
    step(1);
    reset = 1'b0; accel = 6'd4; wr = 1'b1; wdata = 11'd20;
    step(1);
    wr = 1'b0;
    step(3);
    check("midrst_before", vel(), 12);
    reset = 1'b1; div = 8'd2;
    step(1);
    check("midrst_velocity", vel(), 0);
    check("midrst_enable", int'(enable), 0);
    check("midrst_wd_trip", int'(wd_trip), 0);
    check("midrst_at_target", int'(at_target), 1);
    reset = 1'b0; wr = 1'b1; wdata = 11'd20;
    step(1);
    wr = 1'b0;
    check("midrst_rel_enable", int'(enable), 1);
    check("midrst_rel_e1", vel(), 0);
    step(1);
    check("midrst_rel_e2", vel(), 0);
    step(1);
    check("midrst_first_tick", vel(), 4);

    // Write coincident with a tick uses the old target on that tick.
    reset = 1'b1; div = 8'd1; accel = 6'd1;
    step(1);
    reset = 1'b0;
    step(1);
    wr = 1'b1; wdata = 11'd3;
    step(1);
    wr = 1'b0;
    check("wot_tick0", vel(), 0);
    step(1);
    check("wot_idle0", vel(), 0);
    step(1);
    check("wot_tick1", vel(), 1);
    step(1);
    check("wot_idle1", vel(), 1);
    step(1);
    check("wot_tick2", vel(), 2);
    step(2);
    check("wot_tick3", vel(), 3);
    check("wot_at_target", int'(at_target), 1);

    // Watchdog: trips on the 3rd tick after the write, stops on the next.
    reset = 1'b1; div = 8'd3; accel = 6'd0; wdtime = 8'd2;
    step(1);
    reset = 1'b0; wr = 1'b1; wdata = 11'd100;
    step(1);
    wr = 1'b0;
    step(3);
    check("wd_first_tick", vel(), 100);
    check("wd_first_at_target", int'(at_target), 1);
    step(7);
    check("wd_not_yet", int'(wd_trip), 0);
    step(1);
    check("wd_trip_set", int'(wd_trip), 1);
    check("wd_trip_velocity", vel(), 100);
    check("wd_trip_at_target", int'(at_target), 0);
    check("wd_trip_enable", int'(enable), 1);
    step(3);
    check("wd_hold_until_tick", vel(), 100);
    step(1);
    check("wd_stop_velocity", vel(), 0);
    check("wd_stop_enable", int'(enable), 1);
    step(1);
    check("wd_halted_enable", int'(enable), 0);
    wr = 1'b1; wdata = 11'd50;
    step(1);
    wr = 1'b0;
    check("wd_clear", int'(wd_trip), 0);
    step(1);
    check("wd_reenable", int'(enable), 1);
    step(1);
    check("wd_resume", vel(), 50);

    // Most negative write clamps to -1023; accel 0 jumps there in one tick.
    wr = 1'b1; wdata = 11'h400;
    step(1);
    wr = 1'b0;
    step(3);
    check("clamp_velocity", vel(), -1023);
    check("clamp_at_target", int'(at_target), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
